// File: rtl/data_memory_ctrl.sv
// Data memory for the single-cycle datapath.
// It uses a registered-read block RAM with 1- or 2-cycle read latency.
// A ready flag gates requests, so the sweep and the datapath never contend.
// After reset an optional sweep clears every word.
// Sticky flags record read/write collisions and out-of-range addresses.
module data_memory_ctrl #(
    parameter int DATA_WIDTH     = 19,
    parameter int ADDR_WIDTH     = 19,
    parameter int DEPTH          = 4096,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  memRead,
    input  logic                  memWrite,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] dataIn,
    output logic [DATA_WIDTH-1:0] dataOut,
    output logic                  readValid,
    output logic                  ready,
    output logic                  errCollision,
    output logic                  errRange,
    input  logic                  errClear
);
    // Width of the internal word index. DEPTH need not be a power of two.
    localparam int                  MEM_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // DEPTH widened by one bit, so that DEPTH == 2**ADDR_WIDTH still compares correctly.
    localparam logic [ADDR_WIDTH:0] DEPTH_W  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [MEM_AW-1:0]   LAST_PTR = MEM_AW'(DEPTH - 1);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_IDLE  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [MEM_AW-1:0]       ptr_q, ptr_d;
    logic                    ready_q, ready_d;
    logic                    clear_we;
    logic                    err_coll_q, err_range_q;

    logic                    in_range;
    logic                    rd_accept, wr_accept;
    logic                    coll_hit, range_hit;
    logic                    mem_we;
    logic [MEM_AW-1:0]       mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [MEM_AW-1:0]       mem_raddr;

    logic [DATA_WIDTH-1:0]   mem [0:DEPTH-1];
    logic [DATA_WIDTH-1:0]   ram_rd_q;
    logic                    rd_v1_q;

    // Request qualification. Nothing is accepted or flagged while ready is low.
    assign in_range  = ({1'b0, address} < DEPTH_W);
    assign rd_accept = ready_q & memRead & ~memWrite & in_range;
    assign wr_accept = ready_q & memWrite & ~memRead & in_range;
    assign coll_hit  = ready_q & memRead & memWrite;
    assign range_hit = ready_q & (memRead | memWrite) & ~in_range;

    // The RAM has a single write port. It is shared by the clear sweep and by accepted writes.
    assign mem_we    = clear_we | wr_accept;
    assign mem_waddr = clear_we ? ptr_q : address[MEM_AW-1:0];
    assign mem_wdata = clear_we ? '0 : dataIn;
    assign mem_raddr = address[MEM_AW-1:0];

    // State register: the clear sweep or idle, the sweep pointer, and the registered ready flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
            ptr_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ready_q <= ready_d;
        end
    end

    // Next-state logic.
    // The sweep writes one word per cycle. It hands over to idle on the same edge that writes the last word.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        ready_d  = ready_q;
        clear_we = 1'b0;
        unique case (state_q)
            S_CLEAR: begin
                clear_we = 1'b1;
                ptr_d    = ptr_q + 1'b1;
                if (ptr_q == LAST_PTR) begin
                    state_d = S_IDLE;
                    ready_d = 1'b1;
                    ptr_d   = '0;
                end
            end
            S_IDLE: begin
                ready_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Memory write port. The array has no reset so that it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Registered read with enable.
    // The output register only moves on an accepted read, so the last value is held.
    always_ff @(posedge clk) begin
        if (reset) begin
            ram_rd_q <= '0;
        end else if (rd_accept) begin
            ram_rd_q <= mem[mem_raddr];
        end
    end

    // First valid stage. A reset drops any read still in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_v1_q <= 1'b0;
        end else begin
            rd_v1_q <= rd_accept;
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic [DATA_WIDTH-1:0] dout2_q;
            logic                  v2_q;

            // Second output register, for timing. It captures only the words that were actually read.
            always_ff @(posedge clk) begin
                if (reset) begin
                    dout2_q <= '0;
                    v2_q    <= 1'b0;
                end else begin
                    v2_q <= rd_v1_q;
                    if (rd_v1_q) begin
                        dout2_q <= ram_rd_q;
                    end
                end
            end

            assign dataOut   = dout2_q;
            assign readValid = v2_q;
        end else begin : g_lat1
            assign dataOut   = ram_rd_q;
            assign readValid = rd_v1_q;
        end
    endgenerate

    // Sticky error flags. A new error in the same cycle takes priority over errClear.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_coll_q  <= 1'b0;
            err_range_q <= 1'b0;
        end else begin
            if (coll_hit) begin
                err_coll_q <= 1'b1;
            end else if (errClear) begin
                err_coll_q <= 1'b0;
            end
            if (range_hit) begin
                err_range_q <= 1'b1;
            end else if (errClear) begin
                err_range_q <= 1'b0;
            end
        end
    end

    assign ready        = ready_q;
    assign errCollision = err_coll_q;
    assign errRange     = err_range_q;

endmodule
